// File: rtl/fpu_pkg.sv
// Shared constants, result bundle and helpers for the FP64 multiply path.
package fpu_pkg;

  localparam int FP64_W = 64;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  localparam logic [FP64_W-1:0] FP64_QNAN =
    64'h7FF8_0000_0000_0000;

  typedef struct packed {
    logic [FP64_W-1:0] z;
    logic [4:0]        flags;
  } mul_res_t;

  // Leading-zero count of the 106-bit significand product.
  function automatic logic [6:0] lzc106(
    input logic [105:0] v
  );
    lzc106 = 7'd106;
    for (int i = 0; i < 106; i++) begin
      if (v[i]) lzc106 = 7'(105 - i);
    end
  endfunction

endpackage

// File: rtl/fpu_tst_mul64.sv
// Combinational IEEE-754 binary64 multiplier core.
module fpu_tst_mul64
  import fpu_pkg::*;
(
  input  logic [FP64_W-1:0] i_a,
  input  logic [FP64_W-1:0] i_b,
  input  logic [1:0]        i_rm,
  output mul_res_t          o_res
);

  logic        w_sa, w_sb, w_sign;
  logic [10:0] w_ea, w_eb;
  logic [51:0] w_fa, w_fb;
  logic        w_a_zero, w_b_zero;
  logic        w_a_inf, w_b_inf;
  logic        w_a_nan, w_b_nan;
  logic        w_any_nan, w_any_snan;
  logic        w_inv, w_inf, w_zero;

  assign w_sa = i_a[63];
  assign w_sb = i_b[63];
  assign w_ea = i_a[62:52];
  assign w_eb = i_b[62:52];
  assign w_fa = i_a[51:0];
  assign w_fb = i_b[51:0];
  assign w_sign = w_sa ^ w_sb;

  assign w_a_zero = (w_ea == 11'd0) && (w_fa == 52'd0);
  assign w_b_zero = (w_eb == 11'd0) && (w_fb == 52'd0);
  assign w_a_inf  = (w_ea == 11'h7FF) && (w_fa == 52'd0);
  assign w_b_inf  = (w_eb == 11'h7FF) && (w_fb == 52'd0);
  assign w_a_nan  = (w_ea == 11'h7FF) && (w_fa != 52'd0);
  assign w_b_nan  = (w_eb == 11'h7FF) && (w_fb != 52'd0);

  assign w_any_nan  = w_a_nan | w_b_nan;
  assign w_any_snan = (w_a_nan & ~w_fa[51])
                    | (w_b_nan & ~w_fb[51]);

  assign w_inv = ~w_any_nan
    & ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf));
  assign w_inf = ~w_any_nan & ~w_inv
    & (w_a_inf | w_b_inf);
  assign w_zero = ~w_any_nan & ~w_a_inf & ~w_b_inf
    & (w_a_zero | w_b_zero);

  logic [52:0]        w_ma, w_mb;
  logic [10:0]        w_ea_eff, w_eb_eff;
  logic [105:0]       w_prod, w_norm;
  logic [6:0]         w_lz;
  logic signed [13:0] w_exp;
  logic               w_tiny, w_ovf_pre;
  logic [6:0]         w_rsh;
  logic [211:0]       w_wide;
  logic [52:0]        w_m;
  logic               w_g, w_s, w_inx;
  logic               w_inc;
  logic [10:0]        w_efield;
  logic [62:0]        w_sum;
  logic               w_ovf, w_ovf_inf;

  assign w_ma = {w_ea != 11'd0, w_fa};
  assign w_mb = {w_eb != 11'd0, w_fb};
  assign w_ea_eff = (w_ea == 11'd0) ? 11'd1 : w_ea;
  assign w_eb_eff = (w_eb == 11'd0) ? 11'd1 : w_eb;

  assign w_prod = {53'd0, w_ma} * {53'd0, w_mb};
  assign w_lz   = lzc106(w_prod);
  assign w_norm = w_prod << w_lz;

  // Biased exponent of the product with its msb at bit 105.
  assign w_exp = 14'(w_ea_eff) + 14'(w_eb_eff)
               - 14'd1022 - 14'(w_lz);

  assign w_tiny    = w_exp < 14'sd1;
  assign w_ovf_pre = w_exp > 14'sd2046;

  always_comb begin
    w_rsh = 7'd0;
    if (w_exp < -14'sd126) begin
      w_rsh = 7'd127;
    end else if (w_tiny) begin
      w_rsh = 7'(14'sd1 - w_exp);
    end
  end

  assign w_wide = {w_norm, 106'd0} >> w_rsh;
  assign w_m    = w_wide[211:159];
  assign w_g    = w_wide[158];
  assign w_s    = |w_wide[157:0];
  assign w_inx  = w_g | w_s;

  always_comb begin
    w_inc     = 1'b0;
    w_ovf_inf = 1'b1;
    unique case (i_rm)
      RM_RNE: begin
        w_inc     = w_g & (w_s | w_m[0]);
        w_ovf_inf = 1'b1;
      end
      RM_RTZ: begin
        w_inc     = 1'b0;
        w_ovf_inf = 1'b0;
      end
      RM_RDN: begin
        w_inc     = w_sign & w_inx;
        w_ovf_inf = w_sign;
      end
      RM_RUP: begin
        w_inc     = ~w_sign & w_inx;
        w_ovf_inf = ~w_sign;
      end
      default: begin
        w_inc     = 1'b0;
        w_ovf_inf = 1'b1;
      end
    endcase
  end

  // Rounding carry ripples into the exponent field,
  // promoting subnormals and detecting late overflow.
  assign w_efield = w_tiny ? 11'd0 : w_exp[10:0];
  assign w_sum = {w_efield, w_m[51:0]} + 63'(w_inc);
  assign w_ovf = w_ovf_pre | (w_sum[62:52] == 11'h7FF);

  always_comb begin
    o_res = '0;
    unique case (1'b1)
      w_any_nan: begin
        o_res.z = FP64_QNAN;
        o_res.flags[FLG_NV] = w_any_snan;
      end
      w_inv: begin
        o_res.z = FP64_QNAN;
        o_res.flags[FLG_NV] = 1'b1;
      end
      w_inf: begin
        o_res.z = {w_sign, 11'h7FF, 52'd0};
      end
      w_zero: begin
        o_res.z = {w_sign, 63'd0};
      end
      default: begin
        if (w_ovf) begin
          o_res.z = w_ovf_inf
            ? {w_sign, 11'h7FF, 52'd0}
            : {w_sign, 11'h7FE, {52{1'b1}}};
          o_res.flags[FLG_OF] = 1'b1;
          o_res.flags[FLG_NX] = 1'b1;
        end else begin
          o_res.z = {w_sign, w_sum};
          o_res.flags[FLG_UF] = w_tiny & w_inx;
          o_res.flags[FLG_NX] = w_inx;
        end
      end
    endcase
  end

endmodule

// File: rtl/fpu_mul64_pipe.sv
// Two-stage valid/ready wrapper around fpu_tst_mul64 with
// sticky exception flags and a retired-operation counter.
module fpu_mul64_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [63:0]       io_in_a,
  input  logic [63:0]       io_in_b,
  input  logic [1:0]        io_in_rm,
  input  logic [TAG_W-1:0]  io_in_tag,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [63:0]       io_out_z,
  output logic [4:0]        io_out_flags,
  output logic [TAG_W-1:0]  io_out_tag,
  input  logic              io_flush,
  output logic [4:0]        io_fflags,
  input  logic              io_fflags_clr,
  output logic [CNT_W-1:0]  io_count
);

  logic              r_s1_valid;
  logic [63:0]       r_s1_a;
  logic [63:0]       r_s1_b;
  logic [1:0]        r_s1_rm;
  logic [TAG_W-1:0]  r_s1_tag;

  logic              r_s2_valid;
  logic [63:0]       r_s2_z;
  logic [4:0]        r_s2_flags;
  logic [TAG_W-1:0]  r_s2_tag;

  logic [4:0]        r_fflags;
  logic [CNT_W-1:0]  r_count;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_acc;
  logic              w_ret;
  mul_res_t          w_res;

  assign w_s2_adv = ~r_s2_valid | io_out_ready;
  assign w_s1_adv = w_s2_adv;
  assign io_in_ready = ~io_flush & (~r_s1_valid | w_s1_adv);
  assign w_acc = io_in_valid & io_in_ready;
  assign w_ret = r_s2_valid & io_out_ready;

  fpu_tst_mul64 u_mul (
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .i_rm  (r_s1_rm),
    .o_res (w_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (io_flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_acc) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_rm  <= RM_RNE;
      r_s1_tag <= '0;
    end else if (w_acc) begin
      r_s1_a   <= io_in_a;
      r_s1_b   <= io_in_b;
      r_s1_rm  <= io_in_rm;
      r_s1_tag <= io_in_tag;
    end
  end

  // Payload only moves on a real S1->S2 transfer, so a
  // stalled result stays frozen for the consumer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_z     <= '0;
      r_s2_flags <= '0;
      r_s2_tag   <= '0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_s2_z     <= w_res.z;
      r_s2_flags <= w_res.flags;
      r_s2_tag   <= r_s1_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fflags <= '0;
      r_count  <= '0;
    end else begin
      if (w_ret) begin
        r_fflags <= (io_fflags_clr ? 5'd0 : r_fflags)
                  | r_s2_flags;
        r_count  <= r_count + CNT_W'(1);
      end else if (io_fflags_clr) begin
        r_fflags <= '0;
      end
    end
  end

  assign io_out_valid = r_s2_valid;
  assign io_out_z     = r_s2_z;
  assign io_out_flags = r_s2_flags;
  assign io_out_tag   = r_s2_tag;
  assign io_fflags    = r_fflags;
  assign io_count     = r_count;

endmodule

// File: tb/tb_fpu_mul64_pipe.sv
// Scoreboard bench for fpu_mul64_pipe against an exact
// rational-rounding reference model.
module tb_fpu_mul64_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [63:0] io_in_a = '0;
  logic [63:0] io_in_b = '0;
  logic [1:0]  io_in_rm = 2'b00;
  logic [3:0]  io_in_tag = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [63:0] io_out_z;
  logic [4:0]  io_out_flags;
  logic [3:0]  io_out_tag;
  logic        io_flush = 1'b0;
  logic [4:0]  io_fflags;
  logic        io_fflags_clr = 1'b0;
  logic [15:0] io_count;

  fpu_mul64_pipe #(.TAG_W(4), .CNT_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_a       (io_in_a),
    .io_in_b       (io_in_b),
    .io_in_rm      (io_in_rm),
    .io_in_tag     (io_in_tag),
    .io_out_valid  (io_out_valid),
    .io_out_ready  (io_out_ready),
    .io_out_z      (io_out_z),
    .io_out_flags  (io_out_flags),
    .io_out_tag    (io_out_tag),
    .io_flush      (io_flush),
    .io_fflags     (io_fflags),
    .io_fflags_clr (io_fflags_clr),
    .io_count      (io_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] z;
    logic [4:0]  f;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  exp_fflags = '0;
  logic [15:0] exp_count = '0;
  logic        hold_v = 1'b0;
  logic [79:0] hold_pl = '0;

  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp_v, $time);
    end
  endtask

  // Exact product p*2^k rounded onto the binary64 grid.
  function automatic logic [68:0] ref_mul(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [1:0]  rm
  );
    logic s, an, bn, ai, bi, az, bz, nv;
    logic [10:0] ea, eb;
    logic [51:0] fa, fb;
    logic [255:0] p, n, r, half;
    int k, L, qe, sh;
    logic gt, eq, nz, up, tiny, to_inf;
    s  = a[63] ^ b[63];
    ea = a[62:52]; eb = b[62:52];
    fa = a[51:0];  fb = b[51:0];
    an = (ea == 11'h7FF) && (fa != 0);
    bn = (eb == 11'h7FF) && (fb != 0);
    ai = (ea == 11'h7FF) && (fa == 0);
    bi = (eb == 11'h7FF) && (fb == 0);
    az = (ea == 0) && (fa == 0);
    bz = (eb == 0) && (fb == 0);
    if (an || bn) begin
      nv = (an && !fa[51]) || (bn && !fb[51]);
      return {nv, 4'b0000, QNAN};
    end
    if ((ai && bz) || (az && bi)) return {5'b10000, QNAN};
    if (ai || bi) return {5'b0, s, 11'h7FF, 52'd0};
    if (az || bz) return {5'b0, s, 63'd0};
    p = 256'({ea != 0, fa}) * 256'({eb != 0, fb});
    k = (ea == 0 ? 1 : int'(ea))
      + (eb == 0 ? 1 : int'(eb)) - 2150;
    L = 0;
    for (int i = 0; i < 256; i++) if (p[i]) L = i;
    qe = L + k - 52;
    if (qe < -1074) qe = -1074;
    sh = qe - k;
    gt = 0; eq = 0; nz = 0;
    if (sh <= 0) begin
      n = p << (-sh);
    end else if (sh > 200) begin
      n = '0; nz = 1;
    end else begin
      n = p >> sh;
      r = p - (n << sh);
      half = 256'd1 << (sh - 1);
      gt = r > half; eq = r == half; nz = r != 0;
    end
    case (rm)
      2'b00: up = gt || (eq && n[0]);
      2'b01: up = 0;
      2'b10: up = s && nz;
      default: up = !s && nz;
    endcase
    n = n + 256'(up);
    if (n == (256'd1 << 53)) begin
      n = 256'd1 << 52;
      qe++;
    end
    tiny = (L + k) < -1022;
    if (n >= (256'd1 << 52) && qe + 1075 >= 2047) begin
      to_inf = (rm == 2'b00) || (rm == 2'b10 && s)
            || (rm == 2'b11 && !s);
      return {5'b00101, to_inf ? {s, 11'h7FF, 52'd0}
                               : {s, 11'h7FE, {52{1'b1}}}};
    end
    if (n >= (256'd1 << 52))
      return {3'b000, tiny && nz, nz,
              s, 11'(qe + 1075), n[51:0]};
    return {3'b000, tiny && nz, nz, s, 11'd0, n[51:0]};
  endfunction

  function automatic logic [63:0] rnd_fp();
    logic s;
    logic [10:0] e;
    logic [51:0] f;
    s = 1'($urandom_range(0, 1));
    f = 52'({$urandom, $urandom});
    if ($urandom_range(0, 2) == 0) f[39:0] = '0;
    case ($urandom_range(0, 15))
      0: begin e = 0; f = 0; end
      1: begin e = 11'h7FF; f = 0; end
      2: begin e = 11'h7FF; f[0] = 1'b1; end
      3: e = 0;
      4: e = 11'($urandom_range(1500, 2046));
      5: e = 11'($urandom_range(1, 500));
      default: e = 11'($urandom_range(1, 2046));
    endcase
    return {s, e, f};
  endfunction

  // Scoreboard and monitor: all sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [68:0] rv;
    if (!reset_n) begin
      sb.delete();
      exp_fflags = '0;
      exp_count = '0;
      hold_v = 1'b0;
    end else begin
      chk("fflags", 80'(io_fflags), 80'(exp_fflags));
      chk("count", 80'(io_count), 80'(exp_count));
      if (hold_v)
        chk("stall_hold",
            80'({io_out_z, io_out_flags, io_out_tag}), hold_pl);
      if (io_out_valid && io_out_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL retire: got tag %h want none", io_out_tag);
        end else begin
          e = sb.pop_front();
          chk("z", 80'(io_out_z), 80'(e.z));
          chk("flags", 80'(io_out_flags), 80'(e.f));
          chk("tag", 80'(io_out_tag), 80'(e.tag));
          exp_fflags = (io_fflags_clr ? 5'd0 : exp_fflags) | e.f;
        end
        exp_count = exp_count + 16'd1;
      end else if (io_fflags_clr) begin
        exp_fflags = '0;
      end
      hold_v = io_out_valid && !io_out_ready && !io_flush;
      hold_pl = 80'({io_out_z, io_out_flags, io_out_tag});
      if (io_flush) sb.delete();
      if (io_in_valid && io_in_ready) begin
        rv = ref_mul(io_in_a, io_in_b, io_in_rm);
        e.z = rv[63:0]; e.f = rv[68:64]; e.tag = io_in_tag;
        sb.push_back(e);
      end
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] rm, input logic [3:0] tag);
    bit ok = 0;
    io_in_a = a; io_in_b = b; io_in_rm = rm; io_in_tag = tag;
    io_in_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk); ok = io_in_ready;
      @(posedge clk); #1;
    end
    io_in_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL issue: got in_ready=0 want accept, tag %h", tag);
    end
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 20; t++) begin
      if (io_out_valid) return;
      @(posedge clk); #1;
    end
    n_vec++; n_err++;
    $display("FAIL wait_valid: got out_valid=0 want 1");
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (!io_out_valid && sb.size() == 0) return;
      @(posedge clk); #1;
    end
    n_vec++; n_err++;
    $display("FAIL drain: got pending=%0d want 0", sb.size());
  endtask

  task automatic feed_n(input int n);
    int got = 0;
    int guard = 0;
    if (n <= 0) return;
    io_in_a = 64'h3FF0000000000000;
    io_in_b = 64'h3FF0000000000000;
    io_in_rm = 2'b00; io_in_tag = 4'h5;
    io_in_valid = 1'b1;
    while (got < n) begin
      @(negedge clk); if (io_in_ready) got++;
      @(posedge clk); #1;
      guard++;
      if (guard > 2 * n + 100) begin
        n_vec++; n_err++;
        $display("FAIL feed: got %0d accepts want %0d", got, n);
        break;
      end
    end
    io_in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    int nacc, k, need;
    logic [15:0] cbase;
    logic [4:0]  fbase;
    logic [63:0] sa [4];

    #3;
    chk("rst_valid", 80'(io_out_valid), 80'(0));
    chk("rst_z", 80'(io_out_z), 80'(0));
    chk("rst_flags", 80'(io_out_flags), 80'(0));
    chk("rst_tag", 80'(io_out_tag), 80'(0));
    chk("rst_fflags", 80'(io_fflags), 80'(0));
    chk("rst_count", 80'(io_count), 80'(0));
    chk("rst_ready", 80'(io_in_ready), 80'(1));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("ready_after_rst", 80'(io_in_ready), 80'(1));

    // 1.0 * 2.0, latency of two edges
    issue(64'h3FF0000000000000, 64'h4000000000000000, 2'b00, 4'h3);
    chk("lat_edge1", 80'(io_out_valid), 80'(0));
    @(posedge clk); #1;
    chk("lat_edge2", 80'(io_out_valid), 80'(1));
    chk("t1_z", 80'(io_out_z), 80'(64'h4000000000000000));
    chk("t1_flags", 80'(io_out_flags), 80'(0));
    chk("t1_tag", 80'(io_out_tag), 80'(3));
    drain();

    issue(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b00, 4'h1);
    wait_valid();
    chk("t2_z", 80'(io_out_z), 80'(64'h3FF0000000000002));
    chk("t2_flags", 80'(io_out_flags), 80'(5'b00001));
    drain();
    chk("t2_fflags", 80'(io_fflags), 80'(5'b00001));

    issue(64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 2'b00, 4'h2);
    wait_valid();
    chk("t3_z", 80'(io_out_z), 80'(64'h7FF0000000000000));
    chk("t3_flags", 80'(io_out_flags), 80'(5'b00101));
    drain();
    issue(64'h0000000000000000, 64'h7FF0000000000000, 2'b00, 4'h4);
    wait_valid();
    chk("t4_nan", 80'(io_out_z[62:52] == 11'h7FF
                      && io_out_z[51:0] != 0), 80'(1));
    chk("t4_flags", 80'(io_out_flags), 80'(5'b10000));
    drain();
    chk("t4_fflags", 80'(io_fflags), 80'(5'b10101));

    // Stall: four offered, two accepted
    for (int i = 0; i < 4; i++) sa[i] = rnd_fp();
    cbase = exp_count;
    io_out_ready = 1'b0;
    k = 0; nacc = 0;
    io_in_a = sa[0]; io_in_b = sa[3];
    io_in_rm = 2'b00; io_in_tag = 4'h8;
    io_in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk); acc = io_in_valid && io_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        nacc++; k++;
        if (k < 4) begin
          io_in_a = sa[k]; io_in_b = sa[3 - k];
          io_in_tag = 4'(8 + k);
        end else io_in_valid = 1'b0;
      end
    end
    chk("stall_accepts", 80'(nacc), 80'(2));
    chk("stall_ready", 80'(io_in_ready), 80'(0));
    chk("stall_valid", 80'(io_out_valid), 80'(1));
    io_out_ready = 1'b1;
    for (int t = 0; t < 20 && k < 4; t++) begin
      @(negedge clk); acc = io_in_valid && io_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k < 4) begin
          io_in_a = sa[k]; io_in_b = sa[3 - k];
          io_in_tag = 4'(8 + k);
        end else io_in_valid = 1'b0;
      end
    end
    io_in_valid = 1'b0;
    drain();
    chk("stall_count", 80'(io_count), 80'(cbase + 16'd4));

    // Flush with two in flight
    io_out_ready = 1'b0;
    issue(rnd_fp(), rnd_fp(), 2'b00, 4'hA);
    issue(rnd_fp(), rnd_fp(), 2'b01, 4'hB);
    cbase = exp_count; fbase = exp_fflags;
    io_flush = 1'b1;
    #1 chk("flush_ready", 80'(io_in_ready), 80'(0));
    @(posedge clk); #1;
    io_flush = 1'b0;
    chk("flush_valid", 80'(io_out_valid), 80'(0));
    chk("flush_count", 80'(io_count), 80'(cbase));
    chk("flush_fflags", 80'(io_fflags), 80'(fbase));
    io_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("flush_empty", 80'(io_out_valid), 80'(0));

    // Clear in the same cycle as an inexact retire
    issue(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b00, 4'hC);
    wait_valid();
    io_fflags_clr = 1'b1;
    @(posedge clk); #1;
    io_fflags_clr = 1'b0;
    chk("clr_retire", 80'(io_fflags), 80'(5'b00001));
    drain();

    // Random traffic with backpressure, flush and clear
    io_in_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); acc = io_in_valid && io_in_ready;
      @(posedge clk); #1;
      if (acc || !io_in_valid) begin
        io_in_valid = $urandom_range(0, 3) != 0;
        io_in_a = rnd_fp(); io_in_b = rnd_fp();
        io_in_rm = 2'($urandom_range(0, 3));
        io_in_tag = 4'($urandom);
      end
      io_out_ready = $urandom_range(0, 3) != 0;
      io_flush = $urandom_range(0, 60) == 0;
      io_fflags_clr = $urandom_range(0, 30) == 0;
    end
    io_in_valid = 1'b0; io_flush = 1'b0;
    io_fflags_clr = 1'b0; io_out_ready = 1'b1;
    drain();

    // Counter wrap
    need = 65535 - int'(exp_count);
    feed_n(need);
    drain();
    chk("count_max", 80'(io_count), 80'(16'hFFFF));
    feed_n(1);
    drain();
    chk("count_wrap", 80'(io_count), 80'(16'h0000));

    // Asynchronous reset with a full pipe
    io_out_ready = 1'b0;
    issue(64'h4000000000000000, 64'h4000000000000000, 2'b00, 4'h6);
    issue(64'h3FF0000000000001, 64'h3FF0000000000001, 2'b00, 4'h7);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 80'(io_out_valid), 80'(0));
    chk("arst_z", 80'(io_out_z), 80'(0));
    chk("arst_tag", 80'(io_out_tag), 80'(0));
    chk("arst_count", 80'(io_count), 80'(0));
    chk("arst_fflags", 80'(io_fflags), 80'(0));
    chk("arst_ready", 80'(io_in_ready), 80'(1));
    @(posedge clk); #1 reset_n = 1'b1;
    io_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("arst_idle", 80'(io_out_valid), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
